// File: rtl/sram_seq.sv
// sram_seq: streams op1/op2 SRAM pairs through a compute unit into a result SRAM; SRAM_SEQ_PERF_EN adds stall_cnt.
module sram_seq #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] op1_base,
    input  logic [ADDR_WIDTH-1:0] op2_base,
    input  logic [ADDR_WIDTH-1:0] out_base,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic                  op1_ren,
    output logic [ADDR_WIDTH-1:0] op1_radr,
    input  logic [DATA_WIDTH-1:0] op1_rdata,
    output logic                  op2_ren,
    output logic [ADDR_WIDTH-1:0] op2_radr,
    input  logic [DATA_WIDTH-1:0] op2_rdata,
    output logic                  out_wen,
    output logic [ADDR_WIDTH-1:0] out_wadr,
    output logic [DATA_WIDTH-1:0] out_wdata,
`ifdef SRAM_SEQ_PERF_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic                  alu_valid,
    input  logic                  alu_ready,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    input  logic                  res_valid,
    input  logic [DATA_WIDTH-1:0] res_data
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] op1_q, op2_q, out_q, len_q, rd_cnt, wr_cnt;
    logic                  inflight, rp, wp, pop, issue, last_wr;
    logic [1:0]            fifo_cnt, occ;
    logic [DATA_WIDTH-1:0] f1 [2];
    logic [DATA_WIDTH-1:0] f2 [2];

    // occupancy after this cycle's pop; a new read may only issue while it stays below 2
    assign alu_valid = fifo_cnt != '0;
    assign pop       = alu_valid && alu_ready;
    assign occ       = fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    assign issue     = state == RUN && occ < 2'd2;
    assign op1_ren   = issue;
    assign op2_ren   = issue;
    assign op1_radr  = op1_q + rd_cnt;
    assign op2_radr  = op2_q + rd_cnt;
    assign alu_op1   = alu_valid ? f1[rp] : '0;
    assign alu_op2   = alu_valid ? f2[rp] : '0;
    assign out_wen   = res_valid && (state == RUN || state == DRAIN);
    assign out_wadr  = out_q + wr_cnt;
    assign out_wdata = out_wen ? res_data : '0;
    assign last_wr   = out_wen && wr_cnt == len_q - ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            out_q    <= '0;
            len_q    <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            inflight <= 1'b0;
            fifo_cnt <= '0;
            rp       <= 1'b0;
            wp       <= 1'b0;
        end else begin
            inflight <= issue;
            fifo_cnt <= occ;
            if (inflight) begin
                f1[wp] <= op1_rdata;
                f2[wp] <= op2_rdata;
                wp     <= ~wp;
            end
            if (pop) rp <= ~rp;
            if (issue) rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
            if (out_wen) wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
            case (state)
                IDLE: if (start) begin
                    op1_q  <= op1_base;
                    op2_q  <= op2_base;
                    out_q  <= out_base;
                    len_q  <= len;
                    rd_cnt <= '0;
                    wr_cnt <= '0;
                    busy   <= 1'b1;
                    done   <= len == '0;
                    state  <= len == '0 ? DONE : RUN;
                end
                RUN: if (issue && rd_cnt == len_q - ADDR_WIDTH'(1)) state <= DRAIN;
                DRAIN: if (last_wr) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SRAM_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) stall_cnt <= '0;
        else if (alu_valid && !alu_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_sram_seq.sv
// tb_sram_seq: directed bench for sram_seq with SRAM and one-cycle adder models.
module tb_sram_seq;
    localparam int DW = 128;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst, start, alu_ready;
    logic [AW-1:0] op1_base, op2_base, out_base, len;
    logic          busy, done, op1_ren, op2_ren, out_wen, alu_valid, res_valid;
    logic [AW-1:0] op1_radr, op2_radr, out_wadr;
    logic [DW-1:0] op1_rdata, op2_rdata, out_wdata, alu_op1, alu_op2, res_data;
`ifdef SRAM_SEQ_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    sram_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .op1_base(op1_base), .op2_base(op2_base), .out_base(out_base), .len(len),
        .busy(busy), .done(done),
        .op1_ren(op1_ren), .op1_radr(op1_radr), .op1_rdata(op1_rdata),
        .op2_ren(op2_ren), .op2_radr(op2_radr), .op2_rdata(op2_rdata),
        .out_wen(out_wen), .out_wadr(out_wadr), .out_wdata(out_wdata),
`ifdef SRAM_SEQ_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .res_valid(res_valid), .res_data(res_data)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] op1_mem [1024];
    logic [DW-1:0] op2_mem [1024];
    logic [DW-1:0] out_mem [1024];

    // SRAMs with one-cycle read latency and an adder with one-cycle latency
    always @(posedge clk) begin
        if (op1_ren) op1_rdata <= op1_mem[op1_radr];
        if (op2_ren) op2_rdata <= op2_mem[op2_radr];
        res_valid <= alu_valid && alu_ready;
        res_data  <= alu_op1 + alu_op2;
        if (out_wen) out_mem[out_wadr] <= out_wdata;
    end

    int cyc = 0, rd_total = 0, wr_total = 0, done_total = 0, busy_total = 0;
    int pair_err = 0, outst = 0, max_out = 0, nxt;
    int radr_log [256];
    int rcyc_log [256];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (op1_ren && rd_total < 256) begin
            radr_log[rd_total] <= int'(op1_radr);
            rcyc_log[rd_total] <= cyc;
        end
        if (op1_ren) rd_total <= rd_total + 1;
        if (op1_ren != op2_ren) pair_err <= pair_err + 1;
        if (out_wen) wr_total <= wr_total + 1;
        if (done) done_total <= done_total + 1;
        if (busy) busy_total <= busy_total + 1;
        nxt = rst ? 0 : outst + int'(op1_ren) - int'(alu_valid && alu_ready);
        outst <= nxt;
        if (nxt > max_out) max_out <= nxt;
    end

    int tests = 0, fails = 0;
    int r0, w0, d0, b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] o, input logic [AW-1:0] n);
        op1_base = a;
        op2_base = b;
        out_base = o;
        len      = n;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 300) begin
            tick();
            k++;
        end
        chk(tag, done, 1);
    endtask

    task automatic snap();
        r0 = rd_total;
        w0 = wr_total;
        d0 = done_total;
        b0 = busy_total;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; alu_ready = 1'b1;
        op1_base = '0; op2_base = '0; out_base = '0; len = '0;
        for (int i = 0; i < 8; i++) begin
            op1_mem[i] = DW'(i + 1);
            op2_mem[i] = DW'(10 * (i + 1));
        end
        op1_mem[1022] = 5;
        op1_mem[1023] = 6;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ren", {op1_ren, op2_ren}, 0);
        chk("rst_wen", out_wen, 0);
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_radr", {op1_radr, op2_radr, out_wadr}, 0);
        chk("rst_data", {out_wdata, alu_op1, alu_op2}, 0);
        rst = 1'b0;
        tick();

        // basic 4-element job, full throughput
        snap();
        go(0, 0, 100, 4);
        wait_done("j1_done");
        tick(); tick();
        chk("j1_done_cnt", done_total - d0, 1);
        chk("j1_reads", rd_total - r0, 4);
        chk("j1_writes", wr_total - w0, 4);
        chk("j1_back_to_back", rcyc_log[r0 + 3] - rcyc_log[r0], 3);
        for (int i = 0; i < 4; i++) chk("j1_mem", out_mem[100 + i], DW'(11 * (i + 1)));
        chk("j1_idle", busy, 0);

        // five stall cycles mid-stream
        snap();
        go(0, 0, 200, 4);
        tick(); tick();
        alu_ready = 1'b0;
        repeat (5) tick();
        alu_ready = 1'b1;
        wait_done("j2_done");
        tick(); tick();
        for (int i = 0; i < 4; i++) chk("j2_mem", out_mem[200 + i], DW'(11 * (i + 1)));
        chk("j2_max_outstanding", max_out <= 2, 1);
        chk("j2_reads", rd_total - r0, 4);
`ifdef SRAM_SEQ_PERF_EN
        chk("j2_stall_cnt", stall_cnt, 5);
`endif

        // zero-length job
        snap();
        go(0, 0, 0, 0);
        chk("j3_done", done, 1);
        chk("j3_busy", busy, 1);
        tick();
        chk("j3_done_low", done, 0);
        chk("j3_busy_low", busy, 0);
        tick();
        chk("j3_reads", rd_total - r0, 0);
        chk("j3_writes", wr_total - w0, 0);
        chk("j3_busy_cycles", busy_total - b0, 1);
        chk("j3_done_cnt", done_total - d0, 1);

        // address wrap past 2^ADDR_WIDTH
        snap();
        go(1022, 0, 300, 4);
        wait_done("j4_done");
        tick();
        chk("j4_radr0", radr_log[r0], 1022);
        chk("j4_radr1", radr_log[r0 + 1], 1023);
        chk("j4_radr2", radr_log[r0 + 2], 0);
        chk("j4_radr3", radr_log[r0 + 3], 1);
        chk("j4_mem0", out_mem[300], 15);
        chk("j4_mem1", out_mem[301], 26);
        chk("j4_mem2", out_mem[302], 31);
        chk("j4_mem3", out_mem[303], 42);

        // reset in the middle of an 8-element job
        snap();
        go(0, 0, 400, 8);
        for (int k = 0; k < 100 && wr_total - w0 < 2; k++) tick();
        chk("j5_two_written", wr_total - w0 >= 2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("j5_busy", busy, 0);
        chk("j5_done", done, 0);
        chk("j5_ren", {op1_ren, op2_ren}, 0);
        chk("j5_wen", out_wen, 0);
        chk("j5_alu_valid", alu_valid, 0);
        chk("j5_adr", {op1_radr, op2_radr, out_wadr}, 0);
        chk("j5_data", {out_wdata, alu_op1, alu_op2}, 0);
        snap();
        repeat (6) tick();
        chk("j5_no_done", done_total - d0, 0);
        chk("j5_no_write", wr_total - w0, 0);
        snap();
        go(0, 0, 500, 8);
        wait_done("j5b_done");
        tick(); tick();
        chk("j5b_done_cnt", done_total - d0, 1);
        for (int i = 0; i < 8; i++) chk("j5b_mem", out_mem[500 + i], DW'(11 * (i + 1)));

        // start pulse while running is ignored
        snap();
        go(0, 0, 600, 4);
        op1_base = 500; out_base = 700; len = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("j6_done");
        tick(); tick();
        chk("j6_reads", rd_total - r0, 4);
        chk("j6_writes", wr_total - w0, 4);
        chk("j6_done_cnt", done_total - d0, 1);
        for (int i = 0; i < 4; i++) chk("j6_radr", radr_log[r0 + i], i);
        for (int i = 0; i < 4; i++) chk("j6_mem", out_mem[600 + i], DW'(11 * (i + 1)));

        chk("ren_paired", pair_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
